// File: rtl/uart_pattern_pkg.sv
// Shared types and constants for the UART pattern-select controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Build option UART_PARITY_EN enables the PARITY state in uart_rx.
package uart_pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CLEANUP
  } rx_state_e;

  localparam logic [7:0] ASCII_PATTERN_BASE = 8'h30;
  localparam logic [2:0] PATTERN_MAX        = 3'd7;

endpackage

// File: rtl/uart_rx.sv
// UART deframer: 2-flop synchronizer, mid-bit sampling, stop/parity check (UART_PARITY_EN adds even parity).
// Latency: o_RX_DV / o_Frame_Err one cycle after the stop-bit sample. Backpressure: none, strobes are fire-and-forget.
module uart_rx
  import uart_pattern_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  rx_state_e        state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic             cnt_last, cnt_mid, parity_ok;

  assign cnt_last = (clk_cnt_q == CNT_LAST);
  assign cnt_mid  = (clk_cnt_q == CNT_MID);

`ifdef UART_PARITY_EN
  logic par_q, par_d;
  assign parity_ok = ~(^{shift_q, par_q});
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_sync_q) state_d = START;
      START:   if (cnt_mid) state_d = rx_sync_q ? IDLE : DATA;
      DATA: begin
        if (cnt_last && bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY:  if (cnt_last) state_d = STOP;
`endif
      STOP:    if (cnt_last) state_d = CLEANUP;
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_meta_d = i_RX_Serial;
    rx_sync_d = rx_meta_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    bit_idx_d = bit_idx_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
`ifdef UART_PARITY_EN
    par_d     = par_q;
`endif

    // Counter restarts on every state change and after each data bit.
    if (state_q == IDLE || state_d != state_q || (state_q == DATA && cnt_last))
      clk_cnt_d = '0;
    else
      clk_cnt_d = clk_cnt_q + CNT_W'(1);

    if (state_q == IDLE)
      bit_idx_d = '0;

    if (state_q == DATA && cnt_last) begin
      shift_d[bit_idx_q] = rx_sync_q;
      bit_idx_d          = bit_idx_q + 3'd1;
    end

`ifdef UART_PARITY_EN
    if (state_q == PARITY && cnt_last)
      par_d = rx_sync_q;
`endif

    if (state_q == STOP && cnt_last) begin
      if (rx_sync_q && parity_ok) begin
        dv_d   = 1'b1;
        byte_d = shift_q;
      end else begin
        err_d  = 1'b1;
      end
    end
  end

  assign o_RX_Byte   = byte_q;
  assign o_RX_DV     = dv_q;
  assign o_Frame_Err = err_q;

endmodule

// File: rtl/uart_pattern_ctrl.sv
// UART command receiver: ASCII '0'..'7' selects o_Pattern (UART_PARITY_EN selects 8E1 framing).
// Latency: o_Pattern / o_Pattern_Update one cycle after o_RX_DV. Backpressure: none, commands are never stalled.
module uart_pattern_ctrl
  import uart_pattern_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_Frame_Err,
  output logic [2:0] o_Pattern,
  output logic       o_Pattern_Update
);

  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       rx_err;
  logic [7:0] cmd_ofs;
  logic       cmd_hit;
  logic [2:0] pattern_q, pattern_d;
  logic       upd_q, upd_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .CLK        (CLK),
    .i_Reset    (i_Reset),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_Byte  (rx_byte),
    .o_RX_DV    (rx_dv),
    .o_Frame_Err(rx_err)
  );

  // Bytes below the base wrap to large offsets, so one compare covers both ends.
  always_comb begin
    cmd_ofs   = rx_byte - ASCII_PATTERN_BASE;
    cmd_hit   = rx_dv && (cmd_ofs <= {5'd0, PATTERN_MAX});
    pattern_d = cmd_hit ? cmd_ofs[2:0] : pattern_q;
    upd_d     = cmd_hit;
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      pattern_q <= '0;
      upd_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      upd_q     <= upd_d;
    end
  end

  assign o_RX_Byte        = rx_byte;
  assign o_RX_DV          = rx_dv;
  assign o_Frame_Err      = rx_err;
  assign o_Pattern        = pattern_q;
  assign o_Pattern_Update = upd_q;

endmodule

// File: tb/tb_uart_pattern_ctrl.sv
// Directed bench for uart_pattern_ctrl at CLKS_PER_BIT=4 with a queue of expected strobes.
module tb_uart_pattern_ctrl;

  localparam int CLKS = 4;
  localparam int EV_NONE = 0;
  localparam int EV_DV   = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_UPD  = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       CLK;
  logic       i_Reset;
  logic       i_RX_Serial;
  logic [7:0] o_RX_Byte;
  logic       o_RX_DV;
  logic       o_Frame_Err;
  logic [2:0] o_Pattern;
  logic       o_Pattern_Update;

  ev_t sb[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  dv_cyc = -100;

  uart_pattern_ctrl #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .CLK             (CLK),
    .i_Reset         (i_Reset),
    .i_RX_Serial     (i_RX_Serial),
    .o_RX_Byte       (o_RX_Byte),
    .o_RX_DV         (o_RX_DV),
    .o_Frame_Err     (o_Frame_Err),
    .o_Pattern       (o_Pattern),
    .o_Pattern_Update(o_Pattern_Update)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t sb_pop();
    ev_t e;
    if (sb.size() == 0) begin
      e.kind = EV_NONE;
      e.val  = 8'h00;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge CLK) begin
    cyc++;
    if (o_RX_DV || o_Frame_Err)
      check("dv_err_exclusive", 32'({o_RX_DV, o_Frame_Err} == 2'b11), 32'd0);
    if (o_RX_DV) begin
      mon_e = sb_pop();
      check("dv_kind", mon_e.kind, EV_DV);
      check("dv_byte", o_RX_Byte, mon_e.val);
      dv_cyc = cyc;
    end
    if (o_Frame_Err) begin
      mon_e = sb_pop();
      check("err_kind", mon_e.kind, EV_ERR);
    end
    if (o_Pattern_Update) begin
      mon_e = sb_pop();
      check("upd_kind", mon_e.kind, EV_UPD);
      check("upd_pattern", o_Pattern, mon_e.val);
      check("upd_latency", cyc - dv_cyc, 1);
    end
  end

  task automatic line_bit(input logic v);
    i_RX_Serial = v;
    repeat (CLKS) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef UART_PARITY_EN
    line_bit(^b);
`endif
    line_bit(stop);
    i_RX_Serial = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop);
    if (!stop) begin
      sb.push_back('{EV_ERR, 8'h00});
    end else begin
      sb.push_back('{EV_DV, b});
      if (b >= 8'h30 && b <= 8'h37)
        sb.push_back('{EV_UPD, b - 8'h30});
    end
    send_byte(b, stop);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    repeat (8) @(negedge CLK);
    check({tag, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_Reset     = 1'b1;
    i_RX_Serial = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_dv", o_RX_DV, 0);
    check("rst_err", o_Frame_Err, 0);
    check("rst_upd", o_Pattern_Update, 0);
    check("rst_pattern", o_Pattern, 0);
    check("rst_byte", o_RX_Byte, 0);
    i_Reset = 1'b0;
    repeat (4) @(negedge CLK);

    frame(8'h33, 1'b1);
    drain("b33");
    check("b33_pattern", o_Pattern, 3);
    check("b33_byte", o_RX_Byte, 8'h33);

    frame(8'h41, 1'b1);
    drain("b41");
    check("b41_pattern", o_Pattern, 3);

    frame(8'h35, 1'b0);
    drain("b35_bad_stop");
    check("b35_pattern", o_Pattern, 3);
    check("b35_byte_kept", o_RX_Byte, 8'h41);

    i_RX_Serial = 1'b0;
    @(negedge CLK);
    i_RX_Serial = 1'b1;
    drain("glitch");
    check("glitch_pattern", o_Pattern, 3);

    frame(8'h31, 1'b1);
    frame(8'h37, 1'b1);
    drain("b2b");
    check("b2b_pattern", o_Pattern, 7);

    frame(8'h30, 1'b1);
    frame(8'h38, 1'b1);
    frame(8'h2F, 1'b1);
    frame(8'h37, 1'b1);
    frame(8'h37, 1'b1);
    drain("bounds");
    check("bounds_pattern", o_Pattern, 7);

    // 0x36 aborted by reset while in DATA: start bit plus three data bits.
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b1);
    i_Reset     = 1'b1;
    i_RX_Serial = 1'b1;
    repeat (2) @(negedge CLK);
    i_Reset = 1'b0;
    check("midrst_pattern", o_Pattern, 0);
    check("midrst_byte", o_RX_Byte, 0);
    drain("midrst");
    check("midrst_pattern_after", o_Pattern, 0);

    frame(8'h32, 1'b1);
    drain("b32");
    check("b32_pattern", o_Pattern, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_pattern_ctrl.md
UART_PATTERN_CTRL -- requirements
Module: uart_pattern_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per UART bit (25 MHz / 115200); legal range >= 4.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_RX_Serial  input  1  asynchronous UART line, idle high.
REQ-005 SHALL have port o_RX_Byte  output  8  last received byte, LSB first on the line.
REQ-006 SHALL have port o_RX_DV  output  1  one-cycle strobe, o_RX_Byte valid.
REQ-007 SHALL have port o_Frame_Err  output  1  one-cycle strobe, bad stop bit (or parity, see REQ-023).
REQ-008 SHALL have port o_Pattern  output  3  pattern select for the pattern generator.
REQ-009 SHALL have port o_Pattern_Update  output  1  one-cycle strobe, o_Pattern changed.

Function
REQ-010 SHALL pass i_RX_Serial through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, CLEANUP (plus PARITY per REQ-023).
REQ-012 IDLE: synchronized line low -> START, bit counter cleared, clock counter cleared.
REQ-013 START: at clock count (CLKS_PER_BIT-1)/2 SHALL sample the line; low -> DATA with clock counter cleared; high (glitch) -> IDLE, no strobes.
REQ-014 DATA: each CLKS_PER_BIT cycles SHALL sample one bit into bit index 0..7; after index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles SHALL sample; high -> o_RX_Byte updated, o_RX_DV high for exactly one cycle; low -> o_Frame_Err high one cycle, o_RX_Byte unchanged; either case -> CLEANUP.
REQ-016 CLEANUP: one cycle, then IDLE; a start edge occurring during CLEANUP is detected in the following IDLE cycle.
REQ-017 Command decode: on o_RX_DV with byte 0x30..0x37 SHALL load o_Pattern = byte - 0x30 and pulse o_Pattern_Update one cycle after o_RX_DV.
REQ-018 Any other byte, including a byte equal to the current pattern's ASCII code outside 0x30..0x37, SHALL leave o_Pattern unchanged and no update strobe; a valid byte equal to current pattern SHALL still strobe o_Pattern_Update.
REQ-019 o_RX_DV and o_Frame_Err SHALL never be high in the same cycle.
REQ-020 Counters SHALL be sized $clog2(CLKS_PER_BIT) bits; no wrap occurs because counters are cleared on every state transition.

Reset
REQ-021 i_Reset SHALL force state IDLE, counters 0, synchronizer flops 1, o_RX_Byte 0x00, o_RX_DV 0, o_Frame_Err 0, o_Pattern 0, o_Pattern_Update 0, on the next rising edge.
REQ-022 Reset mid-frame SHALL abort the frame with no strobes; reception resumes with the next falling edge after reset deasserts.

Configuration
REQ-023 Macro UART_PARITY_EN: defined -> PARITY state between DATA and STOP samples one even-parity bit; mismatch -> byte discarded, o_Frame_Err pulsed at STOP sample time regardless of stop value; undefined -> no PARITY state, 8N1 framing.

Structure
REQ-024 Shared package uart_pattern_pkg SHALL hold the FSM state enum, ASCII_PATTERN_BASE (0x30) and PATTERN_MAX (7) constants.
REQ-025 Serial deframer (REQ-010..REQ-016) SHALL be a sub-module uart_rx; command decode resides in uart_pattern_ctrl.

Verification (CLKS_PER_BIT=4)
REQ-026 Reset, idle line high -> all outputs 0, o_Pattern 0.
REQ-027 Send 0x33 8N1 -> o_RX_DV pulse with o_RX_Byte 0x33, next cycle o_Pattern_Update, o_Pattern 3.
REQ-028 Send 0x41 -> o_RX_DV with 0x41, no o_Pattern_Update, o_Pattern unchanged.
REQ-029 Send 0x35 with stop bit 0 -> o_Frame_Err pulse, no o_RX_DV, o_Pattern unchanged.
REQ-030 Low glitch of 1 cycle on idle line -> return to IDLE, no strobes; back-to-back frames 0x31 then 0x37 -> o_Pattern 1 then 7.
REQ-031 Assert i_Reset during DATA of 0x36 -> no strobes, o_Pattern 0; following 0x32 -> o_Pattern 2.
